mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles from mem_en issue to mem_rdata valid; legal range 1..4.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while fetch is pending; legal range 1..15.
REQ-003 Port CLK  in  1: single clock; all state changes on the rising edge.
REQ-004 Port RST  in  1: reset, asynchronous assert, active-low.
REQ-005 Ports if_req in 1, if_addr in 32: instruction-fetch request and word address.
REQ-006 Ports if_ack out 1, if_rdata out 32: one-cycle fetch completion pulse and fetched word.
REQ-007 Ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32: CPU data request, 1=write.
REQ-008 Ports d_ack out 1, d_rdata out 32: one-cycle data completion pulse and load data.
REQ-009 Ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32: single-port synchronous memory.
REQ-010 Port stall out 1: high while any request is pending and not acked this cycle; freezes the PC/pipeline.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-012 IDLE: if any req is high, latch the winner's addr/we/wdata, go to ISSUE next cycle.
REQ-013 Priority: data over fetch, except fetch wins when starve_cnt == STARVE_LIMIT and if_req is high.
REQ-014 starve_cnt: +1 on each data grant while if_req is high; clears on any fetch grant or when if_req is low; saturates at STARVE_LIMIT.
REQ-015 ISSUE: mem_en=1 for exactly one cycle, with latched mem_we, mem_addr, mem_wdata.
REQ-016 Write: d_ack pulses in the cycle after ISSUE; FSM returns to IDLE (write latency 2 cycles from grant).
REQ-017 Read: WAIT lasts MEM_LATENCY-1 cycles; if MEM_LATENCY=1, WAIT is skipped.
REQ-018 Read, DONE: capture mem_rdata into if_rdata or d_rdata, pulse the matching ack, return to IDLE.
REQ-019 A new grant is evaluated in IDLE only; no back-to-back issue. Throughput is one transaction per 2+MEM_LATENCY cycles for reads.
REQ-020 Requesters hold req and its payload until ack; a req dropped mid-transaction still completes, and its ack is still pulsed.
REQ-021 if_ack and d_ack are never high in the same cycle.
REQ-022 The rdata outputs hold their last captured value until the next ack for that port.
REQ-023 Simultaneous if_req and d_req in IDLE with starve_cnt < STARVE_LIMIT: grant data; fetch stays pending, stall=1.

Reset
REQ-024 RST low: FSM=IDLE, starve_cnt=0, mem_en=0, mem_we=0, acks=0, stall=0, all data/address outputs 0.
REQ-025 Reset mid-transaction aborts immediately; no ack is produced for the aborted request.

Configuration
REQ-026 Macro ARB_STATS_EN defined: adds out ports stat_if_cnt[15:0], stat_d_cnt[15:0], stat_conflict_cnt[15:0].
REQ-027 These counters count fetch acks, data acks, and IDLE cycles with both reqs high, respectively; all saturate at 16'hFFFF and reset to 0.
REQ-028 ARB_STATS_EN undefined: stat ports and counters are absent; behavior is otherwise identical.

Structure
REQ-029 Package arb_pkg: FSM state enum, LAT_W=3, STARVE_W=4, STAT_W=16.
REQ-030 Sub-module arb_sat_counter (STAT_W-bit saturating counter with inc): instantiated three times under ARB_STATS_EN.

Verification
REQ-031 Fetch read only, if_addr=0x40, MEM_LATENCY=1, mem[0x40]=0x2002000A -> mem_en 1 cycle after grant; if_ack with if_rdata=0x2002000A 2 cycles after grant.
REQ-032 Data write d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1 during ISSUE; d_ack next cycle; later read returns 0xDEADBEEF.
REQ-033 if_req and d_req high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I repeating; stall high throughout.
REQ-034 MEM_LATENCY=3 read -> ack exactly 4 cycles after grant; no mem_en in WAIT.
REQ-035 RST low during WAIT -> no ack; all outputs 0 within the same cycle; a new request after release is served normally.
REQ-036 ARB_STATS_EN, 5 conflicting IDLE cycles -> stat_conflict_cnt=5; a preloaded 0xFFFF counter stays at 0xFFFF.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and widths for the memory port arbiter.
package arb_pkg;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module arb_sat_counter
  import arb_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stop at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and CPU data requests onto one synchronous
// memory port. Data has priority; fetch is forced through after
// STARVE_LIMIT consecutive data grants while fetch waits.
// Optional statistics counters are enabled with the macro ARB_STATS_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_if_cnt,
  output logic [STAT_W-1:0] stat_d_cnt,
  output logic [STAT_W-1:0] stat_conflict_cnt
`endif
);

  localparam logic [STARVE_W-1:0] C_LIMIT = STARVE_W'(STARVE_LIMIT);
  // WAIT length minus one; only meaningful when MEM_LATENCY > 1.
  localparam logic [LAT_W-1:0]    C_WAIT  =
    LAT_W'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

  arb_state_e            r_state, w_state_nxt;
  logic [LAT_W-1:0]      r_lat_cnt, w_lat_nxt;
  logic [STARVE_W-1:0]   r_starve;
  logic                  r_sel_d, r_we;
  logic [31:0]           r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic                  w_req_any, w_grant_if, w_grant;
  logic                  w_done_if, w_done_d, w_cap_if, w_cap_d;

  assign w_req_any  = if_req | d_req;
  // Fetch wins only when data is absent or fetch has hit the starve limit.
  assign w_grant_if = if_req & (~d_req | (r_starve == C_LIMIT));
  assign w_grant    = (r_state == IDLE) & w_req_any;

  assign w_done_if  = (r_state == DONE) & ~r_sel_d;
  assign w_done_d   = (r_state == DONE) &  r_sel_d;
  // Only reads load rdata; write acks leave d_rdata untouched.
  assign w_cap_if   = w_done_if;
  assign w_cap_d    = w_done_d & ~r_we;

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    case (r_state)
      IDLE:  if (w_req_any) w_state_nxt = ISSUE;
      ISSUE: begin
        if (r_we || MEM_LATENCY == 1) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = WAIT;
          w_lat_nxt   = C_WAIT;
        end
      end
      WAIT: begin
        if (r_lat_cnt == '0) w_state_nxt = DONE;
        else                 w_lat_nxt   = r_lat_cnt - 1'b1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
    end
  end

  // Latch the winning request's command at grant time.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sel_d <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_sel_d <= ~w_grant_if;
      r_we    <= w_grant_if ? 1'b0  : d_we;
      r_addr  <= w_grant_if ? if_addr : d_addr;
      r_wdata <= w_grant_if ? '0    : d_wdata;
    end
  end

  // Count data grants made while fetch is waiting; saturate at the limit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                        r_starve <= '0;
    else if (!if_req)                r_starve <= '0;
    else if (w_grant) begin
      if (w_grant_if)                r_starve <= '0;
      else if (r_starve != C_LIMIT)  r_starve <= r_starve + 1'b1;
    end
  end

  // Hold the last word returned to each port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_cap_if) r_if_rdata <= mem_rdata;
      if (w_cap_d)  r_d_rdata  <= mem_rdata;
    end
  end

  // Read data is forwarded straight through in the ack cycle.
  assign if_ack    = w_done_if;
  assign d_ack     = w_done_d;
  assign if_rdata  = w_cap_if ? mem_rdata : r_if_rdata;
  assign d_rdata   = w_cap_d  ? mem_rdata : r_d_rdata;
  assign mem_en    = (r_state == ISSUE);
  assign mem_we    = (r_state == ISSUE) & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  // Held low during reset even if requesters keep their req asserted.
  assign stall     = RST & ((if_req & ~if_ack) | (d_req & ~d_ack));

`ifdef ARB_STATS_EN
  logic w_conflict;
  assign w_conflict = (r_state == IDLE) & if_req & d_req;

  arb_sat_counter #(.W(STAT_W)) u_if_cnt (
    .clk(CLK), .rst_n(RST), .inc(w_done_if), .cnt(stat_if_cnt));
  arb_sat_counter #(.W(STAT_W)) u_d_cnt (
    .clk(CLK), .rst_n(RST), .inc(w_done_d), .cnt(stat_d_cnt));
  arb_sat_counter #(.W(STAT_W)) u_conflict_cnt (
    .clk(CLK), .rst_n(RST), .inc(w_conflict), .cnt(stat_conflict_cnt));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at
// MEM_LATENCY=3, plus a narrow standalone saturating counter.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // DUT 1 (latency 1)
  logic        if_req = 0, if_ack, d_req = 0, d_we = 0, d_ack, stall;
  logic [31:0] if_addr = 0, if_rdata, d_addr = 0, d_wdata = 0, d_rdata;
  logic        m1_en, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  // DUT 2 (latency 3), fetch port only used
  logic        if2_req = 0, if2_ack, d2_ack, stall2;
  logic [31:0] if2_addr = 0, if2_rdata, d2_rdata;
  logic        m2_en, m2_we;
  logic [31:0] m2_addr, m2_wdata, m2_rdata;
  // Standalone counter
  logic        sc_inc = 0;
  logic [3:0]  sc_cnt;
`ifdef ARB_STATS_EN
  logic [15:0] st_if, st_d, st_cf, st2_if, st2_d, st2_cf;
`endif

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .stall(stall)
`ifdef ARB_STATS_EN
    , .stat_if_cnt(st_if), .stat_d_cnt(st_d), .stat_conflict_cnt(st_cf)
`endif
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut2 (
    .CLK(CLK), .RST(RST),
    .if_req(if2_req), .if_addr(if2_addr), .if_ack(if2_ack), .if_rdata(if2_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(d2_ack), .d_rdata(d2_rdata),
    .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
    .mem_rdata(m2_rdata), .stall(stall2)
`ifdef ARB_STATS_EN
    , .stat_if_cnt(st2_if), .stat_d_cnt(st2_d), .stat_conflict_cnt(st2_cf)
`endif
  );

  arb_sat_counter #(.W(4)) u_sc (.clk(CLK), .rst_n(RST), .inc(sc_inc), .cnt(sc_cnt));

  // Shared backing memory; preloaded on the first edge, written by DUT 1.
  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;
  logic [31:0] p1;
  logic [31:0] q [0:2];

  always @(posedge CLK) begin
    if (!mem_init) begin
      mem[10'h040] <= 32'h2002000A;
      mem[10'h080] <= 32'h12345678;
      mem[10'h100] <= 32'h0;
      mem_init     <= 1'b1;
    end else if (m1_en && m1_we) begin
      mem[m1_addr[9:0]] <= m1_wdata;
    end
  end

  always @(posedge CLK) if (m1_en) p1 <= mem[m1_addr[9:0]];
  assign m1_rdata = p1;

  always @(posedge CLK) begin
    if (m2_en) q[0] <= mem[m2_addr[9:0]];
    q[1] <= q[0];
    q[2] <= q[1];
  end
  assign m2_rdata = q[2];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int acks;
    int cyc;

    // Reset state
    tick(); tick();
    chk("rst_mem_en", 32'(m1_en), 0);
    chk("rst_mem_we", 32'(m1_we), 0);
    chk("rst_mem_addr", m1_addr, 0);
    chk("rst_acks", 32'({if_ack, d_ack}), 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    chk("rst_stall", 32'(stall), 0);
    RST = 1'b1;
    tick();

    // Fetch read, latency 1
    if_req = 1; if_addr = 32'h40;
    #1 chk("f_stall_req", 32'(stall), 1);
    tick();
    chk("f_issue_en", 32'(m1_en), 1);
    chk("f_issue_we", 32'(m1_we), 0);
    chk("f_issue_addr", m1_addr, 32'h40);
    chk("f_issue_ack", 32'(if_ack), 0);
    tick();
    chk("f_done_en", 32'(m1_en), 0);
    chk("f_ack", 32'(if_ack), 1);
    chk("f_rdata", if_rdata, 32'h2002000A);
    chk("f_stall_ack", 32'(stall), 0);
    if_req = 0;
    tick();
    chk("f_ack_pulse", 32'(if_ack), 0);
    chk("f_rdata_hold", if_rdata, 32'h2002000A);

    // Data write then read back
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick();
    chk("w_issue_en", 32'(m1_en), 1);
    chk("w_issue_we", 32'(m1_we), 1);
    chk("w_issue_addr", m1_addr, 32'h100);
    chk("w_issue_wdata", m1_wdata, 32'hDEADBEEF);
    chk("w_issue_ack", 32'(d_ack), 0);
    chk("w_issue_stall", 32'(stall), 1);
    tick();
    chk("w_ack", 32'(d_ack), 1);
    chk("w_done_en", 32'(m1_en), 0);
    chk("w_no_if_ack", 32'(if_ack), 0);
    d_req = 0; d_we = 0; d_wdata = 0;
    tick();
    d_req = 1;
    tick();
    chk("r_issue_we", 32'(m1_we), 0);
    tick();
    chk("r_ack", 32'(d_ack), 1);
    chk("r_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 0;
    tick();
    chk("r_rdata_hold", d_rdata, 32'hDEADBEEF);

    // Starvation: both requesters held high
    if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h100;
    #1 chk("s_stall0", 32'(stall), 1);
    acks = 0; cyc = 0;
    while (acks < 10 && cyc < 100) begin
      tick(); cyc++;
      chk("s_stall", 32'(stall), 1);
      chk("s_ack_excl", 32'(if_ack & d_ack), 0);
      if (if_ack || d_ack) begin
        chk($sformatf("s_order%0d", acks), 32'(if_ack), (acks % 5 == 4) ? 32'd1 : 32'd0);
        if (if_ack) chk("s_if_rdata", if_rdata, 32'h2002000A);
        acks++;
      end
    end
    chk("s_ack_total", acks, 10);
    if_req = 0; d_req = 0;
    tick();
`ifdef ARB_STATS_EN
    chk("stat_conflict", 32'(st_cf), 10);
    chk("stat_if", 32'(st_if), 3);
    chk("stat_d", 32'(st_d), 10);
`endif

    // Latency 3 read on DUT 2
    if2_req = 1; if2_addr = 32'h80;
    tick();
    chk("l3_issue_en", 32'(m2_en), 1);
    tick();
    chk("l3_wait1_en", 32'(m2_en), 0);
    chk("l3_wait1_ack", 32'(if2_ack), 0);
    tick();
    chk("l3_wait2_en", 32'(m2_en), 0);
    chk("l3_wait2_ack", 32'(if2_ack), 0);
    tick();
    chk("l3_ack", 32'(if2_ack), 1);
    chk("l3_rdata", if2_rdata, 32'h12345678);
    if2_req = 0;
    tick();

    // Reset during WAIT aborts; request still held through reset
    if2_req = 1; if2_addr = 32'h80;
    tick();
    chk("rw_issue_en", 32'(m2_en), 1);
    tick();
    RST = 0;
    #1;
    chk("rw_ack", 32'(if2_ack), 0);
    chk("rw_en", 32'(m2_en), 0);
    chk("rw_addr", m2_addr, 0);
    chk("rw_rdata", if2_rdata, 0);
    chk("rw_stall", 32'(stall2), 0);
    chk("rw_d_rdata1", d_rdata, 0);
    tick();
    chk("rw_ack_hold", 32'(if2_ack), 0);
    tick();
    RST = 1;
    tick();
    chk("rr_issue_en", 32'(m2_en), 1);
    chk("rr_issue_addr", m2_addr, 32'h80);
    tick();
    chk("rr_wait_ack1", 32'(if2_ack), 0);
    tick();
    chk("rr_wait_ack2", 32'(if2_ack), 0);
    tick();
    chk("rr_ack", 32'(if2_ack), 1);
    chk("rr_rdata", if2_rdata, 32'h12345678);
    if2_req = 0;
    tick();

    // Saturating counter behaviour (4-bit instance)
    sc_inc = 1;
    tick(); tick(); tick();
    chk("sc_cnt3", 32'(sc_cnt), 3);
    for (int i = 0; i < 15; i++) tick();
    chk("sc_sat", 32'(sc_cnt), 15);
    tick();
    chk("sc_sat_hold", 32'(sc_cnt), 15);
    sc_inc = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
